// File: rtl/bat_arb_pkg.sv
// Shared types and encodings for the RAM port arbiter.
package bat_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HALT_WAIT = 2'd1,
        GRANT     = 2'd2,
        RELEASE   = 2'd3
    } arb_state_t;

    localparam logic [1:0] OWNER_CPU  = 2'b00;
    localparam logic [1:0] OWNER_EXT  = 2'b01;
    localparam logic [1:0] OWNER_NONE = 2'b10;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/bat_addr_counter.sv
// Burst address counter: loads a start address, increments per word, wraps silently.
module bat_addr_counter #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] count_o
);

    logic [ADDR_W-1:0] count_q, count_d;

    // Load has priority over increment; natural overflow gives the wrap.
    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = count_q + ADDR_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            // NOTE: non-blocking so all registers update together on the edge.
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the RAM port between the CPU controller and an external loader/DMA port.
// The CPU is halted only at an instruction boundary; the external port then owns the
// RAM for a burst with an auto-incrementing address. After each release the CPU is
// guaranteed CPU_QUANTUM cycles before the external port can request again.
// Optional feature: define ARB_TIMEOUT_EN to bound each grant to MAX_GRANT cycles.
module ram_port_arbiter
    import bat_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned CPU_QUANTUM = 4
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned MAX_GRANT   = 256
`endif
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_ram_rw_i,
    input  logic              cpu_ram_en_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic              cpu_idle_i,
    input  logic              ext_req_i,
    input  logic              ext_rw_i,
    input  logic [ADDR_W-1:0] ext_addr_i,
    input  logic              ext_valid_i,
    input  logic              ext_last_i,
    output logic              ext_gnt_o,
    output logic              ext_ack_o,
    output logic              ext_timeout_o,
    output logic              halt_o,
    output logic              ram_rw_o,
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [1:0]        bus_owner_o
);

    localparam int unsigned CD_W = $clog2(CPU_QUANTUM + 1);

    arb_state_t        state_q, state_d;
    logic [CD_W-1:0]   cooldown_q, cooldown_d;
    logic              ack_q, ack_d;
    logic              accept;
    logic              forced_release;
    logic              rearm_block;
    logic              cnt_load;
    logic [ADDR_W-1:0] burst_addr;

    // A word is taken only in GRANT and only while the request is still held;
    // a VALID in the abort cycle is ignored.
    assign accept   = (state_q == GRANT) && ext_req_i && ext_valid_i;
    assign cnt_load = (state_q == HALT_WAIT) && (state_d == GRANT);

    bat_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (ext_addr_i),
        .inc_i      (accept),
        .count_o    (burst_addr)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned GC_W = $clog2(MAX_GRANT + 1);

    logic [GC_W-1:0] grant_cnt_q, grant_cnt_d;
    logic            timeout_q, timeout_d;
    logic            block_q, block_d;

    assign forced_release = (state_q == GRANT) && (grant_cnt_q == GC_W'(MAX_GRANT - 1));

    // Grant-cycle counter, timeout pulse, and the fresh-request interlock after a timeout.
    always_comb begin
        grant_cnt_d = (state_q == GRANT) ? grant_cnt_q + GC_W'(1) : '0;
        timeout_d   = forced_release && ext_req_i && !(ext_valid_i && ext_last_i);
        block_d     = block_q;
        if (timeout_d) begin
            block_d = 1'b1;
        end else if (!ext_req_i) begin
            block_d = 1'b0;
        end
    end

    // Timeout bookkeeping registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_cnt_q <= '0;
            timeout_q   <= 1'b0;
            block_q     <= 1'b0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            timeout_q   <= timeout_d;
            block_q     <= block_d;
        end
    end

    assign rearm_block   = block_q;
    assign ext_timeout_o = timeout_q;
`else
    assign forced_release = 1'b0;
    assign rearm_block    = 1'b0;
    assign ext_timeout_o  = 1'b0;
`endif

    // State, cooldown and ACK registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cooldown_q <= '0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cooldown_q <= cooldown_d;
            ack_q      <= ack_d;
        end
    end

    // Next-state logic, cooldown reload/decrement and registered ACK.
    always_comb begin
        state_d    = state_q;
        cooldown_d = cooldown_q;
        ack_d      = accept;
        unique case (state_q)
            IDLE: begin
                if (cooldown_q != '0) begin
                    cooldown_d = cooldown_q - CD_W'(1);
                end else if (ext_req_i && !rearm_block) begin
                    state_d = HALT_WAIT;
                end
            end
            HALT_WAIT: begin
                if (!ext_req_i) begin
                    state_d = IDLE;
                end else if (cpu_idle_i && !cpu_ram_en_i) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!ext_req_i || (ext_valid_i && ext_last_i) || forced_release) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d    = IDLE;
                cooldown_d = CD_W'(CPU_QUANTUM);
            end
            default: state_d = IDLE;
        endcase
    end

    // Output muxes: CPU pass-through, external burst, or a quiet turnaround cycle.
    always_comb begin
        ext_gnt_o   = 1'b0;
        halt_o      = 1'b1;
        bus_owner_o = OWNER_CPU;
        ram_rw_o    = cpu_ram_rw_i;
        ram_en_o    = cpu_ram_en_i;
        ram_addr_o  = cpu_addr_i;
        unique case (state_q)
            IDLE: begin
                halt_o = 1'b0;
            end
            HALT_WAIT: begin
                // The controller may still be finishing its bus cycle.
            end
            GRANT: begin
                ext_gnt_o   = 1'b1;
                bus_owner_o = OWNER_EXT;
                ram_rw_o    = ext_rw_i;
                ram_en_o    = accept;
                ram_addr_o  = burst_addr;
            end
            RELEASE: begin
                bus_owner_o = OWNER_NONE;
                ram_rw_o    = RW_READ;
                ram_en_o    = 1'b0;
                ram_addr_o  = burst_addr;
            end
            default: begin
                halt_o = 1'b0;
            end
        endcase
        if (!rst_ni) begin
            ram_en_o = 1'b0;
        end
    end

    assign ext_ack_o = ack_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter (with ARB_TIMEOUT_EN, MAX_GRANT = 8).
module tb_ram_port_arbiter;
    import bat_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_rw, cpu_en, cpu_idle;
    logic [15:0] cpu_addr;
    logic        ext_req, ext_rw, ext_valid, ext_last;
    logic [15:0] ext_addr;
    logic        gnt, ack, tmo, halt, ram_rw, ram_en;
    logic [15:0] ram_addr;
    logic [1:0]  owner;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDR_W      (16),
        .CPU_QUANTUM (4)
`ifdef ARB_TIMEOUT_EN
        ,
        .MAX_GRANT   (8)
`endif
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cpu_ram_rw_i  (cpu_rw),
        .cpu_ram_en_i  (cpu_en),
        .cpu_addr_i    (cpu_addr),
        .cpu_idle_i    (cpu_idle),
        .ext_req_i     (ext_req),
        .ext_rw_i      (ext_rw),
        .ext_addr_i    (ext_addr),
        .ext_valid_i   (ext_valid),
        .ext_last_i    (ext_last),
        .ext_gnt_o     (gnt),
        .ext_ack_o     (ack),
        .ext_timeout_o (tmo),
        .halt_o        (halt),
        .ram_rw_o      (ram_rw),
        .ram_en_o      (ram_en),
        .ram_addr_o    (ram_addr),
        .bus_owner_o   (owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed here.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cpu_rw = 1'b0; cpu_en = 1'b1; cpu_idle = 1'b0; cpu_addr = 16'h0042;
        ext_req = 1'b0; ext_rw = 1'b0; ext_valid = 1'b0; ext_last = 1'b0; ext_addr = 16'h0000;

        // Reset state, RAM_EN forced low even though the CPU drives it.
        #3;
        check("rst_ram_en", ram_en, 0);
        check("rst_halt", halt, 0);
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_tmo", tmo, 0);
        check("rst_owner", owner, OWNER_CPU);
        @(negedge clk);
        rst_n = 1'b1;

        // Pass-through.
        nxt(); cpu_addr = 16'h0042; cpu_en = 1'b1; cpu_rw = RW_WRITE; settle();
        check("pt_addr", ram_addr, 16'h0042);
        check("pt_en", ram_en, 1);
        check("pt_rw", ram_rw, 1);
        check("pt_halt", halt, 0);
        check("pt_owner", owner, OWNER_CPU);

        // EXT_VALID outside GRANT: no access, no ACK.
        nxt(); cpu_en = 1'b0; ext_valid = 1'b1; settle();
        check("stray_en", ram_en, 0);
        nxt(); ext_valid = 1'b0; settle();
        check("stray_ack", ack, 0);

        // Boundary stall: CPU busy for 3 cycles.
        nxt(); ext_req = 1'b1; cpu_idle = 1'b0; cpu_en = 1'b1; ext_addr = 16'h0100; ext_rw = RW_WRITE; settle();
        check("req_halt0", halt, 0);
        for (int i = 0; i < 3; i++) begin
            nxt(); settle();
            check("stall_halt", halt, 1);
            check("stall_gnt", gnt, 0);
            check("stall_cpu_en", ram_en, 1);
        end
        nxt(); cpu_idle = 1'b1; cpu_en = 1'b0; settle();
        check("bound_gnt0", gnt, 0);

        // Burst write 0100..0103.
        nxt(); ext_valid = 1'b1; ext_last = 1'b0; settle();
        check("bw_gnt", gnt, 1);
        check("bw_owner", owner, OWNER_EXT);
        check("bw_addr0", ram_addr, 16'h0100);
        check("bw_en", ram_en, 1);
        check("bw_rw", ram_rw, 1);
        check("bw_ack0", ack, 0);
        for (int i = 1; i < 4; i++) begin
            nxt(); ext_last = (i == 3); settle();
            check("bw_addr", ram_addr, 32'h0100 + i);
            check("bw_ack", ack, 1);
        end
        nxt(); ext_valid = 1'b0; ext_last = 1'b0; ext_req = 1'b0; settle();
        check("rel_owner", owner, OWNER_NONE);
        check("rel_gnt", gnt, 0);
        check("rel_en", ram_en, 0);
        check("rel_halt", halt, 1);
        check("rel_ack", ack, 1);
        nxt(); settle();
        check("post_halt", halt, 0);
        check("post_ack", ack, 0);
        check("post_owner", owner, OWNER_CPU);
        repeat (4) nxt();

        // Wrap FFFF -> 0000 (read), then abort mid-burst.
        nxt(); ext_addr = 16'hFFFF; ext_rw = RW_READ; ext_req = 1'b1; cpu_idle = 1'b1; cpu_en = 1'b0; settle();
        check("wr_halt0", halt, 0);
        nxt(); settle();
        check("wr_halt1", halt, 1);
        check("wr_gnt0", gnt, 0);
        nxt(); ext_valid = 1'b1; settle();
        check("wr_gnt_lat2", gnt, 1);
        check("wr_addr_ffff", ram_addr, 16'hFFFF);
        check("wr_rw", ram_rw, 0);
        check("wr_en", ram_en, 1);
        nxt(); settle();
        check("wr_addr_0000", ram_addr, 16'h0000);
        check("wr_ack", ack, 1);
        nxt(); ext_req = 1'b0; settle();
        check("abort_en", ram_en, 0);
        check("abort_ack", ack, 1);
        nxt(); ext_req = 1'b1; ext_valid = 1'b0; settle();
        check("abort_owner", owner, OWNER_NONE);
        check("abort_noack", ack, 0);

        // Cooldown: re-raised request ignored for the quantum.
        for (int i = 0; i < 5; i++) begin
            nxt(); settle();
            check("cool_halt", halt, 0);
        end
        nxt(); settle();
        check("cool_done_halt", halt, 1);
        nxt(); cpu_en = 1'b1; cpu_addr = 16'h0042; settle();
        check("drop_gnt", gnt, 1);
        check("drop_cpu_en", ram_en, 0);
        check("drop_addr", ram_addr, 16'hFFFF);

        // Reset mid-GRANT.
        cpu_en = 1'b0; ext_valid = 1'b1; #1;
        check("mid_en", ram_en, 1);
        rst_n = 1'b0; #1;
        check("mrst_gnt", gnt, 0);
        check("mrst_halt", halt, 0);
        check("mrst_en", ram_en, 0);
        check("mrst_owner", owner, OWNER_CPU);
        ext_req = 1'b0; ext_valid = 1'b0;
        nxt(); settle();
        check("mrst_ack", ack, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef ARB_TIMEOUT_EN
        // Timeout after 8 GRANT cycles with LAST never set.
        nxt(); ext_req = 1'b1; ext_addr = 16'h0200; settle();
        nxt(); settle();
        check("to_halt", halt, 1);
        for (int i = 0; i < 8; i++) begin
            nxt(); ext_valid = 1'b1; settle();
            check("to_gnt", gnt, 1);
            check("to_tmo0", tmo, 0);
        end
        nxt(); ext_valid = 1'b0; settle();
        check("to_tmo1", tmo, 1);
        check("to_owner", owner, OWNER_NONE);
        nxt(); settle();
        check("to_tmo_end", tmo, 0);
        check("to_halt_end", halt, 0);
        for (int i = 0; i < 7; i++) begin
            nxt(); settle();
            check("to_block_halt", halt, 0);
        end
        nxt(); ext_req = 1'b0; settle();
        nxt(); ext_req = 1'b1; settle();
        check("to_fresh_halt0", halt, 0);
        nxt(); settle();
        check("to_fresh_halt1", halt, 1);
        ext_req = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
